// File: rtl/wb_regfile_pkg.sv
// Shared types and constants for the writeback stage / register file.
//   wb_rec_t     : registered MEM/WR record as seen by writeback
//   commit_rec_t : one-cycle-delayed commit record for difftest
//   ZR_IDX       : register index that reads as zero and discards writes
package wb_regfile_pkg;
  localparam int WB_DW    = 64;
  localparam int WB_CNTW  = 64;
  localparam int WB_NREGS = 31;
  localparam logic [4:0] ZR_IDX = 5'd31;

  typedef struct packed {
    logic             valid;
    logic             wen;
    logic [4:0]       dst;
    logic [WB_DW-1:0] wdata;
    logic             flag_wen;
    logic [3:0]       flags;
    logic [WB_DW-1:0] pc;
    logic [31:0]      instr;
  } wb_rec_t;

  typedef struct packed {
    logic             valid;
    logic [WB_DW-1:0] pc;
    logic [31:0]      instr;
    logic             wen;
    logic [4:0]       dst;
    logic [WB_DW-1:0] wdata;
  } commit_rec_t;
endpackage

// File: rtl/wb_regfile_if.sv
// Bus bundle between the pipeline/decode side and wb_regfile.
//   master : pipeline side (drives the wb_* record and read addresses)
//   slave  : wb_regfile (drives read data, flags, commit record, counter)
interface wb_regfile_if #(
  parameter int DW   = 64,
  parameter int CNTW = 64
);
  logic          wb_valid;
  logic          wb_wen;
  logic [4:0]    wb_dst;
  logic [DW-1:0] wb_wdata;
  logic          wb_flag_wen;
  logic [3:0]    wb_flags;
  logic [DW-1:0] wb_pc;
  logic [31:0]   wb_instr;
  logic [4:0]    rd_addr1;
  logic [4:0]    rd_addr2;
  logic [DW-1:0] rd_data1;
  logic [DW-1:0] rd_data2;
  logic [3:0]    nzcv;
  logic          commit_valid;
  logic [DW-1:0] commit_pc;
  logic [31:0]   commit_instr;
  logic          commit_wen;
  logic [4:0]    commit_dst;
  logic [DW-1:0] commit_wdata;
  logic [CNTW-1:0] retire_cnt;

  modport master (
    output wb_valid, wb_wen, wb_dst, wb_wdata, wb_flag_wen, wb_flags, wb_pc, wb_instr,
    output rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, nzcv,
    input  commit_valid, commit_pc, commit_instr, commit_wen, commit_dst, commit_wdata,
    input  retire_cnt
  );
  modport slave (
    input  wb_valid, wb_wen, wb_dst, wb_wdata, wb_flag_wen, wb_flags, wb_pc, wb_instr,
    input  rd_addr1, rd_addr2,
    output rd_data1, rd_data2, nzcv,
    output commit_valid, commit_pc, commit_instr, commit_wen, commit_dst, commit_wdata,
    output retire_cnt
  );
endinterface

// File: rtl/wb_regfile_gpr_bank.sv
// NREGS x DW general-purpose register storage.
//   clk_i, rst_ni : clock, synchronous active-low clear of all entries
//   we_i, waddr_i, wdata_i : single write port (addresses >= NREGS ignored)
//   raddr_i / rdata_o      : NRP combinational read ports, out-of-range reads 0
module wb_regfile_gpr_bank #(
  parameter int NREGS = 31,
  parameter int DW    = 64,
  parameter int NRP   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [4:0]              waddr_i,
  input  logic [DW-1:0]           wdata_i,
  input  logic [NRP-1:0][4:0]     raddr_i,
  output logic [NRP-1:0][DW-1:0]  rdata_o
);
  logic [NREGS-1:0][DW-1:0] mem_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)                                 mem_q <= '0;
    else if (we_i && (32'(waddr_i) < NREGS))     mem_q[waddr_i] <= wdata_i;
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    assign rdata_o[p] = (32'(raddr_i[p]) < NREGS) ? mem_q[raddr_i[p]] : '0;
  end
endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: commits the MEM/WR record to the GPRs and NZCV, serves
// two decode read ports with write-first bypass, and emits a registered
// commit record plus retired-instruction count.
//   clk  : clock
//   rst  : synchronous active-low reset
//   bus  : wb_regfile_if.slave (wb_* record in; reads, flags, commit out)
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int NREGS = WB_NREGS,
  parameter int DW    = WB_DW,
  parameter int CNTW  = WB_CNTW
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);
  wb_rec_t     wb;
  commit_rec_t commit_d, commit_q;
  logic [3:0]      nzcv_q;
  logic [CNTW-1:0] cnt_q;
  logic            do_w, do_f;
  logic [1:0][4:0]    raddr;
  logic [1:0][DW-1:0] bank_rd, rd;

  assign wb = '{valid: bus.wb_valid, wen: bus.wb_wen, dst: bus.wb_dst,
                wdata: bus.wb_wdata, flag_wen: bus.wb_flag_wen,
                flags: bus.wb_flags, pc: bus.wb_pc, instr: bus.wb_instr};

  // XZR writes still retire and commit, they just never touch storage.
  assign do_w = wb.valid & wb.wen & (wb.dst != ZR_IDX);
  assign do_f = wb.valid & wb.flag_wen;

  assign raddr = {bus.rd_addr2, bus.rd_addr1};

  wb_regfile_gpr_bank #(.NREGS(NREGS), .DW(DW), .NRP(2)) u_bank (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (do_w),
    .waddr_i (wb.dst),
    .wdata_i (wb.wdata),
    .raddr_i (raddr),
    .rdata_o (bank_rd)
  );

  // Write-first bypass: decode sees this cycle's result before it lands.
  for (genvar p = 0; p < 2; p++) begin : g_byp
    assign rd[p] = (raddr[p] == ZR_IDX)            ? '0 :
                   (do_w && raddr[p] == wb.dst)    ? wb.wdata :
                                                     bank_rd[p];
  end

  assign bus.rd_data1 = rd[0];
  assign bus.rd_data2 = rd[1];
  assign bus.nzcv     = do_f ? wb.flags : nzcv_q;

  always_comb begin
    commit_d       = '0;
    commit_d.valid = wb.valid;
    commit_d.pc    = wb.pc;
    commit_d.instr = wb.instr;
    commit_d.wen   = do_w;
    commit_d.dst   = wb.dst;
    commit_d.wdata = wb.wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      nzcv_q   <= '0;
      commit_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_f) nzcv_q <= wb.flags;
      commit_q <= commit_d;
      cnt_q    <= cnt_q + CNTW'(wb.valid);
    end
  end

  assign bus.commit_valid = commit_q.valid;
  assign bus.commit_pc    = commit_q.pc;
  assign bus.commit_instr = commit_q.instr;
  assign bus.commit_wen   = commit_q.wen;
  assign bus.commit_dst   = commit_q.dst;
  assign bus.commit_wdata = commit_q.wdata;
  assign bus.retire_cnt   = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_regfile_if #(.DW(64), .CNTW(64)) bus ();

  wb_regfile dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: architectural state after each edge.
  logic [63:0] m_gpr [32];
  logic [3:0]  m_nzcv;
  logic [63:0] m_cnt;
  logic        e_cv, e_cwen;
  logic [63:0] e_pc, e_wdata;
  logic [31:0] e_instr;
  logic [4:0]  e_dst;

  // Combinational outputs captured during the cycle.
  logic [63:0] c_rd1, c_rd2;
  logic [3:0]  c_nz;

  typedef struct {
    logic        v, wen, fw;
    logic [4:0]  dst, a1, a2;
    logic [63:0] wd;
    logic [3:0]  fl;
    logic [63:0] x_rd1, x_rd2;
    logic [3:0]  x_nz;
    logic        x_cv, x_cwen;
    logic [63:0] x_cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_nzcv = '0; m_cnt = '0;
    e_cv = 0; e_cwen = 0; e_pc = '0; e_wdata = '0; e_instr = '0; e_dst = '0;
  endtask

  // Architectural register contents as they will stand after this record commits.
  function automatic logic [63:0] m_peek(input logic [4:0] a, input logic v, input logic wen,
                                         input logic [4:0] dst, input logic [63:0] wd);
    logic [63:0] nxt [32];
    nxt = m_gpr;
    if (v && wen) nxt[dst] = wd;
    nxt[31] = '0;
    return nxt[a];
  endfunction

  function automatic logic [3:0] m_flags(input logic v, input logic fw, input logic [3:0] fl);
    return (v && fw) ? fl : m_nzcv;
  endfunction

  task automatic m_edge(input logic r, input logic v, input logic wen, input logic [4:0] dst,
                        input logic [63:0] wd, input logic fw, input logic [3:0] fl,
                        input logic [63:0] pc, input logic [31:0] ins);
    if (!r) m_clear();
    else begin
      if (v && wen && dst != 5'd31) m_gpr[dst] = wd;
      if (v && fw) m_nzcv = fl;
      m_cnt += 64'(v);
      e_cv = v; e_pc = pc; e_instr = ins; e_dst = dst; e_wdata = wd;
      e_cwen = v && wen && dst != 5'd31;
    end
  endtask

  // One cycle: drive at negedge, capture combinational outputs, clock, settle.
  task automatic drive(input logic r, input logic v, input logic wen, input logic [4:0] dst,
                       input logic [63:0] wd, input logic fw, input logic [3:0] fl,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [63:0] pc, input logic [31:0] ins);
    @(negedge clk);
    rst = r;
    bus.wb_valid = v; bus.wb_wen = wen; bus.wb_dst = dst; bus.wb_wdata = wd;
    bus.wb_flag_wen = fw; bus.wb_flags = fl; bus.wb_pc = pc; bus.wb_instr = ins;
    bus.rd_addr1 = a1; bus.rd_addr2 = a2;
    #1;
    c_rd1 = bus.rd_data1; c_rd2 = bus.rd_data2; c_nz = bus.nzcv;
    @(posedge clk);
    #1;
  endtask

  task automatic model_cycle(input logic r, input logic v, input logic wen, input logic [4:0] dst,
                             input logic [63:0] wd, input logic fw, input logic [3:0] fl,
                             input logic [4:0] a1, input logic [4:0] a2,
                             input logic [63:0] pc, input logic [31:0] ins);
    logic [63:0] x1, x2;
    logic [3:0]  xn;
    x1 = m_peek(a1, v, wen, dst, wd);
    x2 = m_peek(a2, v, wen, dst, wd);
    xn = m_flags(v, fw, fl);
    drive(r, v, wen, dst, wd, fw, fl, a1, a2, pc, ins);
    chk("rd_data1", c_rd1, x1);
    chk("rd_data2", c_rd2, x2);
    chk("nzcv", 64'(c_nz), 64'(xn));
    m_edge(r, v, wen, dst, wd, fw, fl, pc, ins);
    chk("commit_valid", 64'(bus.commit_valid), 64'(e_cv));
    if (e_cv) begin
      chk("commit_pc", bus.commit_pc, e_pc);
      chk("commit_instr", 64'(bus.commit_instr), 64'(e_instr));
      chk("commit_wen", 64'(bus.commit_wen), 64'(e_cwen));
      chk("commit_dst", 64'(bus.commit_dst), 64'(e_dst));
      chk("commit_wdata", bus.commit_wdata, e_wdata);
    end
    chk("retire_cnt", bus.retire_cnt, m_cnt);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 4'd0, 5'(i), 5'(31 - i), '0, '0);
      chk({tag, "_rd1"}, c_rd1, 64'd0);
      chk({tag, "_rd2"}, c_rd2, 64'd0);
    end
    chk({tag, "_nzcv"}, 64'(bus.nzcv), 64'd0);
    chk({tag, "_retire"}, bus.retire_cnt, 64'd0);
  endtask

  localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_0001;
  vec_t vt [7];

  initial begin
    rst = 1'b0;
    bus.wb_valid = 0; bus.wb_wen = 0; bus.wb_dst = '0; bus.wb_wdata = '0;
    bus.wb_flag_wen = 0; bus.wb_flags = '0; bus.wb_pc = '0; bus.wb_instr = '0;
    bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    m_clear();

    // Reset state, including full commit record.
    drive(1'b0, 1'b1, 1'b1, 5'd3, 64'h55, 1'b1, 4'hF, 5'd0, 5'd0, 64'h40, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 4'd0, 5'd0, 5'd0, '0, '0);
    chk("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
    chk("rst_commit_wen", 64'(bus.commit_wen), 64'd0);
    chk("rst_commit_dst", 64'(bus.commit_dst), 64'd0);
    chk("rst_commit_pc", bus.commit_pc, 64'd0);
    chk("rst_commit_instr", 64'(bus.commit_instr), 64'd0);
    chk("rst_commit_wdata", bus.commit_wdata, 64'd0);
    check_all_zero("reset");

    // Directed table from a freshly reset state.
    //        v  wen fw dst   a1    a2    wd          fl       rd1   rd2   nz       cv cwen cnt
    vt[0] = '{1, 1, 0, 5'd5,  5'd5, 5'd31, DB,        4'h0,    DB,   0,    4'h0,    1, 1, 1};
    vt[1] = '{0, 1, 0, 5'd5,  5'd5, 5'd5,  64'h1234,  4'h0,    DB,   DB,   4'h0,    0, 0, 1};
    vt[2] = '{1, 1, 0, 5'd31, 5'd31,5'd5,  64'hFFFF,  4'h0,    0,    DB,   4'h0,    1, 0, 2};
    vt[3] = '{1, 0, 1, 5'd0,  5'd5, 5'd0,  64'h0,     4'b1010, DB,   0,    4'b1010, 1, 0, 3};
    vt[4] = '{1, 1, 0, 5'd0,  5'd0, 5'd0,  64'h7,     4'h0,    64'h7,64'h7,4'b1010, 1, 1, 4};
    vt[5] = '{1, 1, 0, 5'd0,  5'd0, 5'd5,  64'h9,     4'h0,    64'h9,DB,   4'b1010, 1, 1, 5};
    vt[6] = '{0, 0, 1, 5'd0,  5'd0, 5'd5,  64'h0,     4'b0101, 64'h9,DB,   4'b1010, 0, 0, 5};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vt[i].v, vt[i].wen, vt[i].dst, vt[i].wd, vt[i].fw, vt[i].fl,
            vt[i].a1, vt[i].a2, 64'h1000 + 64'(4 * i), 32'(i));
      m_edge(1'b1, vt[i].v, vt[i].wen, vt[i].dst, vt[i].wd, vt[i].fw, vt[i].fl,
             64'h1000 + 64'(4 * i), 32'(i));
      chk($sformatf("t%0d_rd1", i), c_rd1, vt[i].x_rd1);
      chk($sformatf("t%0d_rd2", i), c_rd2, vt[i].x_rd2);
      chk($sformatf("t%0d_nzcv", i), 64'(c_nz), 64'(vt[i].x_nz));
      chk($sformatf("t%0d_cvalid", i), 64'(bus.commit_valid), 64'(vt[i].x_cv));
      chk($sformatf("t%0d_cwen", i), 64'(bus.commit_wen), 64'(vt[i].x_cwen));
      chk($sformatf("t%0d_retire", i), bus.retire_cnt, vt[i].x_cnt);
      if (vt[i].x_cv) begin
        chk($sformatf("t%0d_cpc", i), bus.commit_pc, 64'h1000 + 64'(4 * i));
        chk($sformatf("t%0d_cdst", i), 64'(bus.commit_dst), 64'(vt[i].dst));
      end
    end
    // X5 read from storage after the bypass cycle.
    drive(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 4'd0, 5'd5, 5'd0, '0, '0);
    chk("x5_stored", c_rd1, DB);
    chk("x0_last_wins", c_rd2, 64'h9);
    chk("nzcv_held", 64'(c_nz), 64'(4'b1010));

    // Reset with a write in flight: write dropped, bypass still visible that cycle.
    drive(1'b0, 1'b1, 1'b1, 5'd7, 64'hABCD, 1'b1, 4'hC, 5'd7, 5'd5, 64'h2000, 32'h7);
    chk("rst_cyc_bypass", c_rd1, 64'hABCD);
    chk("rst_commit_valid2", 64'(bus.commit_valid), 64'd0);
    m_clear();
    check_all_zero("midrst");

    // Randomized records against the reference model.
    for (int n = 0; n < 1000; n++) begin
      logic r, v, wen, fw;
      logic [4:0] dst, a1, a2;
      logic [63:0] wd;
      r   = ($urandom_range(0, 99) != 0);
      v   = ($urandom_range(0, 3) != 0);
      wen = ($urandom_range(0, 3) != 0);
      fw  = ($urandom_range(0, 2) == 0);
      dst = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      a1  = ($urandom_range(0, 2) == 0) ? dst : 5'($urandom_range(0, 31));
      a2  = ($urandom_range(0, 2) == 0) ? dst : 5'($urandom_range(0, 31));
      wd  = {$urandom, $urandom};
      model_cycle(r, v, wen, dst, wd, fw, 4'($urandom), a1, a2, {$urandom, $urandom}, $urandom);
    end
    // Final sweep of GPR contents.
    for (int i = 0; i < 32; i++)
      model_cycle(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 4'd0, 5'(i), 5'(31 - i), '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WR pipeline register: the writeback stage plus architectural state.
- Takes the registered memory-stage record and commits its result to a 31x64 general-purpose register file and the NZCV flags.
- Serves two decode-stage read ports with same-cycle write bypass.
- Emits a registered commit record and a retired-instruction counter for difftest and performance monitoring.

Parameters:
- NREGS, 31, number of writable GPRs (X0..X30); index 31 is XZR.
- DW, 64, datapath width.
- CNTW, 64, retire counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low: rst==0 at a rising edge resets.
- wb_valid  in  1  record from MEM/WR is a real instruction; 0 = bubble.
- wb_wen  in  1  GPR write request.
- wb_dst  in  5  destination register index.
- wb_wdata  in  DW  result value.
- wb_flag_wen  in  1  NZCV write request.
- wb_flags  in  4  new NZCV value, bit3=N .. bit0=V.
- wb_pc  in  DW  PC of the record.
- wb_instr  in  32  instruction word.
- rd_addr1, rd_addr2  in  5 each  decode read addresses.
- rd_data1, rd_data2  out  DW each  read data, combinational.
- nzcv  out  4  current flags, with bypass.
- commit_valid  out  1  registered commit strobe.
- commit_pc  out  DW  PC of the committed instruction.
- commit_instr  out  32  instruction word of the committed instruction.
- commit_wen  out  1  committed instruction wrote a GPR.
- commit_dst  out  5  GPR index written.
- commit_wdata  out  DW  value written.
- retire_cnt  out  CNTW  retired-instruction count.

Behaviour:
- Commit condition: `do_w = wb_valid & wb_wen & (wb_dst != 31)`; `do_f = wb_valid & wb_flag_wen`. Bubbles (wb_valid=0) change no state; all other wb_* fields are ignored.
- GPR write: at the rising edge with rst=1 and do_w, `gpr[wb_dst] <= wb_wdata`.
- Flags write: at the rising edge with rst=1 and do_f, `nzcv_q <= wb_flags`.
- Write to index 31 (XZR) is discarded. If wb_valid=1 it still counts as retired and still produces a commit record, with commit_wen=0.
- Reads are combinational:
  - addr==31 -> 0.
  - else if do_w and addr==wb_dst -> wb_wdata (write-first bypass).
  - else gpr[addr].
- Both read ports are independent. Both may hit the same address and the bypass in the same cycle.
- `nzcv = do_f ? wb_flags : nzcv_q`.
- Commit record: one-cycle latency, registered every edge.
  - commit_valid <= wb_valid.
  - commit_pc <= wb_pc.
  - commit_instr <= wb_instr.
  - commit_wen <= do_w.
  - commit_dst <= wb_dst.
  - commit_wdata <= wb_wdata.
  - A bubble drives commit_valid=0. The other commit fields may update but are don't-care.
- retire_cnt: increments by 1 at each edge where wb_valid=1. Wraps from all-ones to 0 with no flag.
- Reset (rst=0 at an edge), takes priority over any simultaneous write:
  - all gpr <= 0, nzcv_q <= 0.
  - commit_valid=0, commit_wen=0, commit_dst=0, commit_pc=0, commit_instr=0, commit_wdata=0.
  - retire_cnt=0.
- Reset mid-stream: the in-flight write is dropped. After reset, reads return 0 in the same cycle unless bypass applies.
- Back-to-back writes to the same register: the last one wins; each is visible via bypass in its own cycle.
- No stall input: the upstream register already drives wb_valid=0 on stall, so a stall shows up here as a bubble.

Decomposition:
- Shared pipes package:
  - writeback record typedef: valid, wen, dst, wdata, flag_wen, flags, pc, instr.
  - commit record typedef.
  - constant ZR_IDX=5'd31.
- Sub-module gpr_bank: NREGS x DW storage, one synchronous write port, two combinational read ports, reset clear.
- Bypass logic, flags register, commit register and counter stay in wb_regfile.

Test Plan:
- Reset, then read all indices 0..31 -> rd_data1/2 = 0, nzcv=0, retire_cnt=0, commit_valid=0.
- Write X5=64'hDEAD_BEEF_0000_0001 with rd_addr1=5 in the same cycle -> rd_data1 shows the value that cycle (bypass). Next cycle, from storage: same value. Commit record shows dst=5, wen=1.
- Write dst=31 with wdata=64'hFFFF and wb_valid=1 -> rd_data(31)=0; commit_valid=1, commit_wen=0; retire_cnt +1.
- Write wen=1 with wb_valid=0 (bubble) -> register unchanged, commit_valid=0, retire_cnt unchanged.
- flag_wen with flags=4'b1010 -> nzcv=4'b1010 in the same cycle and stays after. An asserted rst (0) on the next edge -> nzcv=0, all GPRs 0, retire_cnt=0.
- 1000 random valid/bubble records vs a reference model -> GPR contents, retire_cnt = number of valid records, and the commit stream all match.
